dec_ram: RTL and testbench

Two-bank, single-port synchronous RAM used by the LDPC decoder to hold per-bit decision/message words. The `rs` (region select) input picks one of two independent banks, each RAM_DEPTH words of DATA_WIDTH bits. This allows ping-pong storage, e.g. current vs. next iteration. Chip select gates all activity; reads are registered with one-cycle latency.

---
 rtl/dec_ram_pkg.sv | 11 +
 rtl/dec_ram_bank.sv | 34 +++
 rtl/dec_ram.sv | 84 ++++++++
 tb/tb_dec_ram.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_ram_pkg.sv
// Shared constants for the LDPC decoder two-bank decision/message RAM.
package dec_ram_pkg;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    localparam int DEC_DATA_WIDTH    = 1;
    localparam int DEC_ADDRESS_WIDTH = 8;
    localparam int DEC_RAM_DEPTH     = 256;

endpackage

// File: rtl/dec_ram_bank.sv
// Single-port synchronous RAM bank: write enable, registered read, unreset array.
module dec_ram_bank #(
    parameter int DATA_WIDTH    = 1,
    parameter int ADDRESS_WIDTH = 8,
    parameter int RAM_DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  in_range_s;

    // Only meaningful when the bank is shallower than the address space.
    assign in_range_s = (int'(addr_i) < RAM_DEPTH);

    // Array write and read register; the read register holds between reads.
    always_ff @(posedge clk) begin
        if (we_i && in_range_s) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= in_range_s ? mem_q[addr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dec_ram.sv
// Two-bank single-port RAM for the LDPC decoder with registered, reset-masked read data.
module dec_ram
    import dec_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEC_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEC_ADDRESS_WIDTH,
    parameter int RAM_DEPTH     = DEC_RAM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     we,
    input  logic                     cs,
    input  logic                     rs,
    output logic [DATA_WIDTH-1:0]    data_out
);

    logic                  we0_s, we1_s, re0_s, re1_s;
    logic [DATA_WIDTH-1:0] rd0_s, rd1_s;
    logic [DATA_WIDTH-1:0] data_out_s;
    logic                  rs_q;
    logic                  vld_q;

    assign we0_s = cs & we  & (rs == BANK0);
    assign we1_s = cs & we  & (rs == BANK1);
    assign re0_s = cs & ~we & (rs == BANK0);
    assign re1_s = cs & ~we & (rs == BANK1);

    dec_ram_bank #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH)
    ) u_bank0 (
        .clk     (clk),
        .we_i    (we0_s),
        .re_i    (re0_s),
        .addr_i  (address),
        .wdata_i (data_in),
        .rdata_o (rd0_s)
    );

    dec_ram_bank #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RAM_DEPTH     (RAM_DEPTH)
    ) u_bank1 (
        .clk     (clk),
        .we_i    (we1_s),
        .re_i    (re1_s),
        .addr_i  (address),
        .wdata_i (data_in),
        .rdata_o (rd1_s)
    );

    // Remember which bank served the last read; vld_q masks stale bank data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q  <= BANK0;
            vld_q <= 1'b0;
        end else if (cs && !we) begin
            rs_q  <= rs;
            vld_q <= 1'b1;
        end else begin
            rs_q  <= rs_q;
            vld_q <= vld_q;
        end
    end

    // Output mux over the two registered bank outputs.
    always_comb begin
        data_out_s = '0;
        if (!vld_q) begin
            data_out_s = '0;
        end else if (rs_q == BANK1) begin
            data_out_s = rd1_s;
        end else begin
            data_out_s = rd0_s;
        end
    end

    assign data_out = data_out_s;

endmodule

// File: tb/tb_dec_ram.sv
// Self-checking bench for dec_ram against an array-based behavioural model.
module tb_dec_ram;

    localparam int DW    = 1;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic          we;
    logic          cs;
    logic          rs;
    logic [DW-1:0] data_out;

    logic [DW-1:0] model [2][DEPTH];
    logic [DW-1:0] exp_q;
    int            n_cmp;
    int            n_err;

    dec_ram #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .RAM_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .cs       (cs),
        .rs       (rs),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clocked operation; the model follows the plain read/write rules.
    task automatic drive(input logic c, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cs = c; we = w; rs = r; address = a; data_in = d;
        @(posedge clk);
        if (!rst_n) exp_q = '0;
        else if (c && w) model[r][a] = d;
        else if (c && !w) exp_q = model[r][a];
        #1;
    endtask

    task automatic test_reset();
        cs = 1'b1; we = 1'b0; rs = 1'b0; address = 8'h00; data_in = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL reset_async: data_out=%0b expected 0", data_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(i), 1'b0);
            n_cmp++;
            if (data_out !== 1'b0) begin
                n_err++; $display("FAIL reset_hold: data_out=%0b expected 0", data_out);
            end
        end
        @(negedge clk); cs = 1'b0; rst_n = 1'b1; exp_q = '0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL reset_release: data_out=%0b expected 0", data_out);
        end
    endtask

    task automatic test_fill_bank0();
        for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, 1'b0, 8'(a), 1'($urandom));
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(a), 1'b0);
            n_cmp++;
            if (data_out !== exp_q) begin
                n_err++; $display("FAIL fill_bank0 addr=%0d: data_out=%0b expected %0b", a, data_out, exp_q);
            end
        end
    endtask

    task automatic test_isolation();
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                drive(1'b1, 1'b1, 1'b0, 8'(a), 1'(p == 0));
                drive(1'b1, 1'b1, 1'b1, 8'(a), 1'(p != 0));
            end
            drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b0);
            n_cmp++;
            if (data_out !== 1'(p == 0)) begin
                n_err++; $display("FAIL isolation_b0 p=%0d: data_out=%0b expected %0b", p, data_out, 1'(p == 0));
            end
            drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
            n_cmp++;
            if (data_out !== 1'(p != 0)) begin
                n_err++; $display("FAIL isolation_b1 p=%0d: data_out=%0b expected %0b", p, data_out, 1'(p != 0));
            end
        end
    endtask

    task automatic test_cs_gating();
        drive(1'b1, 1'b1, 1'b0, 8'h10, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h11, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h10, 1'b0);
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL cs_idle_hold: data_out=%0b expected 0", data_out);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h10, 1'b0);
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL cs_idle_read: data_out=%0b expected 0", data_out);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_err++; $display("FAIL cs_no_write: data_out=%0b expected 1", data_out);
        end
    endtask

    task automatic test_write_hold();
        drive(1'b1, 1'b1, 1'b0, 8'h20, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_err++; $display("FAIL hold_read20: data_out=%0b expected 1", data_out);
        end
        drive(1'b1, 1'b1, 1'b0, 8'h21, 1'b0);
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_err++; $display("FAIL hold_on_write: data_out=%0b expected 1", data_out);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h21, 1'b0);
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL hold_read21: data_out=%0b expected 0", data_out);
        end
    endtask

    task automatic test_boundary();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] want  [4];
        addrs = '{8'h00, 8'hFF, 8'h01, 8'hFE};
        want  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                drive(1'b1, 1'b1, 1'(b), 8'(a), 1'(a == 0 || a == DEPTH - 1));
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, 1'b0, 1'(b), addrs[k], 1'b0);
                n_cmp++;
                if (data_out !== want[k]) begin
                    n_err++; $display("FAIL boundary b=%0d addr=%0h: data_out=%0b expected %0b", b, addrs[k], data_out, want[k]);
                end
            end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  8'($urandom), 1'($urandom));
            n_cmp++;
            if (data_out !== exp_q) begin
                n_err++; $display("FAIL random i=%0d: data_out=%0b expected %0b", i, data_out, exp_q);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_err++; $display("FAIL midreset_pre: data_out=%0b expected 1", data_out);
        end
        #2 rst_n = 1'b0; exp_q = '0;
        #1;
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_err++; $display("FAIL midreset_async: data_out=%0b expected 0", data_out);
        end
        @(negedge clk); cs = 1'b0; rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_err++; $display("FAIL midreset_mem_kept: data_out=%0b expected 1", data_out);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_q = '0;
        rst_n = 1'b1; cs = 1'b0; we = 1'b0; rs = 1'b0; address = '0; data_in = '0;
        test_reset();
        test_fill_bank0();
        test_isolation();
        test_cs_gating();
        test_write_hold();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
